// File: rtl/multi_cycle_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode and ALU flags in, state plus every
// write enable and mux select out.
interface multi_cycle_control_unit_if #(
   parameter int OP_W = 6
);
   logic [OP_W-1:0] opcode;
   logic            zero;
   logic            sign;
   logic [2:0]      state;
   logic            PCWre;
   logic            IRWre;
   logic            RegWre;
   logic            mRD;
   logic            mWR;
   logic [1:0]      RegDst;
   logic            ALUSrcA;
   logic            ALUSrcB;
   logic            ExtSel;
   logic            DBDataSrc;
   logic            WrRegDSrc;
   logic [1:0]      PCSrc;
   logic [2:0]      ALUOp;

   modport master (
      input  opcode, zero, sign,
      output state, PCWre, IRWre, RegWre, mRD, mWR, RegDst, ALUSrcA, ALUSrcB,
             ExtSel, DBDataSrc, WrRegDSrc, PCSrc, ALUOp
   );

   modport slave (
      output opcode, zero, sign,
      input  state, PCWre, IRWre, RegWre, mRD, mWR, RegDst, ALUSrcA, ALUSrcB,
             ExtSel, DBDataSrc, WrRegDSrc, PCSrc, ALUOp
   );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: steps each instruction through IF/ID/EXE/MEM/WB
// and decodes datapath controls from (state, opcode, zero, sign).
module multi_cycle_control_unit #(
   parameter int              OP_W    = 6,
   parameter logic [OP_W-1:0] OP_HALT = 6'b111111
) (
   input logic                     CLK,
   input logic                     Reset,
   multi_cycle_control_unit_if.master bus
);

   localparam logic [2:0] S_IF   = 3'b000;
   localparam logic [2:0] S_ID   = 3'b001;
   localparam logic [2:0] S_EXE  = 3'b010;
   localparam logic [2:0] S_MEM  = 3'b011;
   localparam logic [2:0] S_WB   = 3'b100;
   localparam logic [2:0] S_HALT = 3'b101;

   localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
   localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
   localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
   localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
   localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
   localparam logic [OP_W-1:0] OP_SLT  = 6'b100110;
   localparam logic [OP_W-1:0] OP_SLTI = 6'b100111;
   localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b110101;
   localparam logic [OP_W-1:0] OP_BLTZ = 6'b110110;
   localparam logic [OP_W-1:0] OP_J    = 6'b111000;
   localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
   localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;

   logic [2:0] state_q, state_d;
   logic is_rtype, is_imm, is_lw, is_sw, is_branch, is_jal, is_jump, is_halt;
   logic is_alu, taken;

   always_comb begin
      is_rtype  = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                  (bus.opcode == OP_OR)  || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_SLL) || (bus.opcode == OP_SLT);
      is_imm    = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ORI) ||
                  (bus.opcode == OP_SLTI);
      is_lw     = (bus.opcode == OP_LW);
      is_sw     = (bus.opcode == OP_SW);
      is_branch = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE) ||
                  (bus.opcode == OP_BLTZ);
      is_jal    = (bus.opcode == OP_JAL);
      is_jump   = (bus.opcode == OP_J) || (bus.opcode == OP_JR) || is_jal;
      is_halt   = (bus.opcode == OP_HALT);
      is_alu    = is_rtype || is_imm;
      taken     = ((bus.opcode == OP_BEQ)  &&  bus.zero) ||
                  ((bus.opcode == OP_BNE)  && !bus.zero) ||
                  ((bus.opcode == OP_BLTZ) &&  bus.sign);
   end

   // Undefined opcodes fall through to IF from ID, so they behave as a NOP.
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF:   state_d = S_ID;
         S_ID:   state_d = is_halt ? S_HALT :
                           (is_alu || is_lw || is_sw || is_branch) ? S_EXE : S_IF;
         S_EXE:  state_d = is_branch ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB;
         S_MEM:  state_d = is_lw ? S_WB : S_IF;
         S_WB:   state_d = S_IF;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values; blocking here would create ordering-dependent races.
   always_ff @(posedge CLK) begin
      if (Reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   assign bus.state = state_q;

   // NOTE: every output gets a default at the top of the block so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      bus.PCWre     = 1'b0;
      bus.IRWre     = 1'b0;
      bus.RegWre    = 1'b0;
      bus.mRD       = 1'b0;
      bus.mWR       = 1'b0;
      bus.RegDst    = 2'b00;
      bus.ALUSrcA   = (bus.opcode == OP_SLL);
      bus.ALUSrcB   = is_imm || is_lw || is_sw;
      bus.ExtSel    = (bus.opcode != OP_ORI);
      bus.DBDataSrc = is_lw;
      bus.WrRegDSrc = !is_jal;
      bus.PCSrc     = 2'b00;
      bus.ALUOp     = 3'b000;

      if (is_rtype)                   bus.RegDst = 2'b10;
      else if (is_imm || is_lw)       bus.RegDst = 2'b01;

      case (bus.opcode)
         OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: bus.ALUOp = 3'b001;
         OP_SLL:                          bus.ALUOp = 3'b010;
         OP_OR, OP_ORI:                   bus.ALUOp = 3'b011;
         OP_AND:                          bus.ALUOp = 3'b100;
         OP_SLT, OP_SLTI:                 bus.ALUOp = 3'b101;
         default:                         bus.ALUOp = 3'b000;
      endcase

      if (bus.opcode == OP_J || is_jal)           bus.PCSrc = 2'b11;
      else if (bus.opcode == OP_JR)               bus.PCSrc = 2'b10;
      else if (state_q == S_EXE && is_branch && taken) bus.PCSrc = 2'b01;

      // PCWre fires in the last state of each instruction's path.
      case (state_q)
         S_IF:  bus.IRWre = 1'b1;
         S_ID: begin
            bus.PCWre  = !(is_alu || is_lw || is_sw || is_branch || is_halt);
            bus.RegWre = is_jal;
         end
         S_EXE: bus.PCWre = is_branch;
         S_MEM: begin
            bus.PCWre = is_sw;
            bus.mRD   = is_lw;
            bus.mWR   = is_sw;
         end
         S_WB: begin
            bus.PCWre  = is_alu || is_lw;
            bus.RegWre = is_alu || is_lw;
         end
         default: ;
      endcase

      if (Reset) begin
         bus.PCWre  = 1'b0;
         bus.IRWre  = 1'b0;
         bus.RegWre = 1'b0;
         bus.mWR    = 1'b0;
      end
   end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Control FSM for the multi-cycle CPU core, directly upstream of the datapath that `CPU_multi_cycle` instantiates.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath write-enable and mux select from the current state, the opcode held in IR, and the ALU `zero`/`sign` flags.
- Replaces the single-cycle combinational decoder; the top-level testbench drives `CLK` and `Reset` unchanged apart from reset polarity.

Parameters:
- `OP_W`, 6: opcode width.
- `OP_HALT`, 6'b111111: halt opcode.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high; returns the FSM to IF.
- `opcode`  in  `OP_W`  IR[31:26], stable from ID onward.
- `zero`  in  1  ALU result == 0 (valid in EXE).
- `sign`  in  1  ALU result[31] (valid in EXE).
- `state`  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
- `PCWre`  out  1  PC write enable.
- `IRWre`  out  1  IR write enable.
- `RegWre`  out  1  register-file write enable.
- `mRD`  out  1  data memory read.
- `mWR`  out  1  data memory write.
- `RegDst`  out  2  write-register select: 00 $31, 01 rt, 10 rd.
- `ALUSrcA`  out  1  1 = shamt (sll).
- `ALUSrcB`  out  1  1 = extended immediate.
- `ExtSel`  out  1  1 = sign-extend, 0 = zero-extend.
- `DBDataSrc`  out  1  1 = memory data, 0 = ALU result.
- `WrRegDSrc`  out  1  1 = DB bus, 0 = PC+4 (jal).
- `PCSrc`  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- `ALUOp`  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed).

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110, slti 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010
  - halt = `OP_HALT`
- The state register is the only storage. All other outputs are combinational from (state, opcode, zero, sign).
- Reset:
  - On the `CLK` edge with `Reset`=1, state becomes IF.
  - While `Reset`=1, `PCWre`, `IRWre`, `RegWre` and `mWR` are forced to 0 regardless of state.
  - All other outputs follow their normal decode.
  - Reset takes priority at any point in any state, including HALT and mid-instruction.
- Transitions:
  - IF -> ID always.
  - ID -> IF for j/jr/jal and for undefined opcodes; ID -> HALT for halt; otherwise ID -> EXE.
  - EXE -> IF for beq/bne/bltz; EXE -> MEM for lw/sw; otherwise EXE -> WB.
  - MEM -> IF for sw; MEM -> WB for lw.
  - WB -> IF.
  - HALT -> HALT until `Reset`.
- Instruction lengths in cycles: j/jr/jal/undefined 2, branch 3, sw 4, R-type/immediate ALU 4, lw 5.
- Enable pulses:
  - `IRWre`=1 only in IF.
  - `PCWre`=1 exactly once per instruction, in its final state: ID for j/jr/jal/undefined, EXE for branches, MEM for sw, WB for the rest. `PCWre`=0 in HALT.
  - `RegWre`=1 in WB for ALU ops and lw, and in ID for jal. It is 0 otherwise.
  - `mRD`=1 in MEM for lw; `mWR`=1 in MEM for sw.
- `PCSrc`:
  - 11 for j/jal; 10 for jr.
  - 01 in EXE when the branch is taken: beq & zero, bne & !zero, bltz & sign.
  - 00 otherwise, including a not-taken branch.
- Branches use `ALUOp`=001 (sub); bltz compares rs with $0.
- `RegDst`: 10 for R-type (add/sub/or/and/sll/slt); 01 for addi/ori/slti/lw; 00 for jal.
- `ALUSrcB`=1 for addi/ori/slti/lw/sw. `ALUSrcA`=1 only for sll.
- `ExtSel`=0 for ori only; 1 otherwise.
- `DBDataSrc`=1 only for lw. `WrRegDSrc`=0 only for jal.
- Undefined opcode acts as a NOP: no register or memory write, PC+4.

Test Plan:
- Reset=1 for 2 edges, then release -> state=000 and `IRWre`=1 in the first cycle. `PCWre`/`RegWre`/`mWR` stay 0 while Reset is held.
- add (000000) from IF -> states 000, 001, 010, 100. `PCWre`=1 and `RegWre`=1 only in cycle 4, `RegDst`=10, `ALUOp`=000.
- lw (110001) -> 5 states ending MEM, WB. `mRD`=1 in MEM; `DBDataSrc`=1, `RegWre`=1, `PCWre`=1 in WB. sw (110000) -> `mWR`=1 and `PCWre`=1 in MEM, then IF.
- beq with zero=1 -> `PCSrc`=01 and `PCWre`=1 in EXE, then IF. Same with zero=0 -> `PCSrc`=00. bne with zero=0 -> 01. bltz with sign=1 -> 01.
- jal (111010) -> in ID: `PCSrc`=11, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0, `PCWre`=1; next state IF.
- Edge cases:
  - halt -> state 101 held for 20 cycles with all enables 0.
  - Reset pulse -> IF.
  - Reset asserted during the MEM cycle of sw -> `mWR`=0 on that cycle, and state=IF on the next edge.
